// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner: FSM states,
// default timing parameters, key map and column drive patterns.
package keypad_pkg;

  localparam int SCAN_DIV_DEFAULT     = 1000;
  localparam int DEBOUNCE_CNT_DEFAULT = 100000;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HOLD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // Row r, column c to hex legend of the physical keypad
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] drv;
    case (idx)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = 4'b1110;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad decoder with press/release debounce; emits one
// key_valid pulse per accepted press and holds the decoded code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEFAULT,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] decode,
  output logic       key_valid
);

  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);

  logic [3:0]        row_meta_r, row_sync_r;
  state_t            state_r, state_s;
  logic [1:0]        col_idx_r, col_idx_s;
  logic [3:0]        col_r, col_s;
  logic [SCAN_W-1:0] scan_cnt_r, scan_cnt_s;
  logic [DB_W-1:0]   db_cnt_r, db_cnt_s;
  logic [1:0]        key_row_r, key_row_s;
  logic [3:0]        decode_r, decode_s;
  logic              key_valid_r, key_valid_s;
  logic [1:0]        low_row_s;
  logic              any_low_s;
  logic              key_low_s;

  // Two-flop synchronizer; idle value is all rows released (high)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // Lowest-numbered low row wins when several rows are pulled down
  always_comb begin
    casez (row_sync_r)
      4'b???0: low_row_s = 2'd0;
      4'b??01: low_row_s = 2'd1;
      4'b?011: low_row_s = 2'd2;
      4'b0111: low_row_s = 2'd3;
      default: low_row_s = 2'd0;
    endcase
  end

  assign any_low_s = (row_sync_r != 4'hF);
  assign key_low_s = ~row_sync_r[key_row_r];

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= SCAN;
      col_idx_r   <= 2'd0;
      col_r       <= 4'b1110;
      scan_cnt_r  <= '0;
      db_cnt_r    <= '0;
      key_row_r   <= 2'd0;
      decode_r    <= 4'h0;
      key_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      col_idx_r   <= col_idx_s;
      col_r       <= col_s;
      scan_cnt_r  <= scan_cnt_s;
      db_cnt_r    <= db_cnt_s;
      key_row_r   <= key_row_s;
      decode_r    <= decode_s;
      key_valid_r <= key_valid_s;
    end
  end

  // Next-state logic; column only advances after a full scan slot or a debounced release
  always_comb begin
    state_s     = state_r;
    col_idx_s   = col_idx_r;
    scan_cnt_s  = scan_cnt_r;
    db_cnt_s    = db_cnt_r;
    key_row_s   = key_row_r;
    decode_s    = decode_r;
    key_valid_s = 1'b0;
    case (state_r)
      SCAN: begin
        if (scan_cnt_r == SCAN_LAST) begin
          scan_cnt_s = '0;
          db_cnt_s   = '0;
          if (any_low_s) begin
            state_s   = PRESS_DB;
            key_row_s = low_row_s;
          end else begin
            col_idx_s = col_idx_r + 2'd1;
          end
        end else begin
          scan_cnt_s = scan_cnt_r + SCAN_W'(1);
        end
      end
      PRESS_DB: begin
        if (key_low_s) begin
          if (db_cnt_r == DB_LAST) begin
            state_s     = HOLD;
            db_cnt_s    = '0;
            decode_s    = key_code(key_row_r, col_idx_r);
            key_valid_s = 1'b1;
          end else begin
            db_cnt_s = db_cnt_r + DB_W'(1);
          end
        end else begin
          state_s    = SCAN;
          db_cnt_s   = '0;
          scan_cnt_s = '0;
        end
      end
      HOLD: begin
        if (!any_low_s) begin
          state_s  = RELEASE_DB;
          db_cnt_s = '0;
        end else begin
          state_s = HOLD;
        end
      end
      RELEASE_DB: begin
        if (!any_low_s) begin
          if (db_cnt_r == DB_LAST) begin
            state_s    = SCAN;
            db_cnt_s   = '0;
            scan_cnt_s = '0;
            col_idx_s  = col_idx_r + 2'd1;
          end else begin
            db_cnt_s = db_cnt_r + DB_W'(1);
          end
        end else begin
          state_s  = HOLD;
          db_cnt_s = '0;
        end
      end
      default: begin
        state_s    = SCAN;
        scan_cnt_s = '0;
        db_cnt_s   = '0;
      end
    endcase
    col_s = col_drive(col_idx_s);
  end

  assign col       = col_r;
  assign decode    = decode_r;
  assign key_valid = key_valid_r;

endmodule
